// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared memory op codes, FSM encodings and bus constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

    localparam int unsigned c_REG_BUS      = 32;
    localparam int unsigned c_REG_ADDR_BUS = 5;
    localparam logic [31:0] c_ZERO_WORD    = 32'h0000_0000;
    localparam logic        c_RST_ENABLE   = 1'b1;

    localparam logic [3:0] c_OP_NONE = 4'd0;
    localparam logic [3:0] c_OP_LB   = 4'd1;
    localparam logic [3:0] c_OP_LBU  = 4'd2;
    localparam logic [3:0] c_OP_LH   = 4'd3;
    localparam logic [3:0] c_OP_LHU  = 4'd4;
    localparam logic [3:0] c_OP_LW   = 4'd5;
    localparam logic [3:0] c_OP_SB   = 4'd6;
    localparam logic [3:0] c_OP_SH   = 4'd7;
    localparam logic [3:0] c_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Byte enables, store lane replication and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic              is_mem,
    output logic              is_store,
    output logic              misaligned,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] store_lanes,
    output logic [DATA_W-1:0] load_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be_byte;
    logic [3:0]  w_be_half;

    assign w_byte    = rdata[{addr_lo, 3'b000} +: 8];
    assign w_half    = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign w_be_byte = 4'b0001 << addr_lo;
    assign w_be_half = addr_lo[1] ? 4'b1100 : 4'b0011;

    always_comb begin
        is_mem      = 1'b0;
        is_store    = 1'b0;
        misaligned  = 1'b0;
        be          = 4'b0000;
        store_lanes = '0;
        load_ext    = '0;
        case (op)
            c_OP_LB: begin
                is_mem   = 1'b1;
                be       = w_be_byte;
                load_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
            end
            c_OP_LBU: begin
                is_mem   = 1'b1;
                be       = w_be_byte;
                load_ext = {{(DATA_W-8){1'b0}}, w_byte};
            end
            c_OP_LH: begin
                is_mem     = 1'b1;
                misaligned = addr_lo[0];
                be         = w_be_half;
                load_ext   = {{(DATA_W-16){w_half[15]}}, w_half};
            end
            c_OP_LHU: begin
                is_mem     = 1'b1;
                misaligned = addr_lo[0];
                be         = w_be_half;
                load_ext   = {{(DATA_W-16){1'b0}}, w_half};
            end
            c_OP_LW: begin
                is_mem     = 1'b1;
                misaligned = |addr_lo;
                be         = 4'b1111;
                load_ext   = rdata;
            end
            // Stores replicate into every lane so the bus only needs the enables
            c_OP_SB: begin
                is_mem      = 1'b1;
                is_store    = 1'b1;
                be          = w_be_byte;
                store_lanes = {(DATA_W/8){store_data[7:0]}};
            end
            c_OP_SH: begin
                is_mem      = 1'b1;
                is_store    = 1'b1;
                misaligned  = addr_lo[0];
                be          = w_be_half;
                store_lanes = {(DATA_W/16){store_data[15:0]}};
            end
            c_OP_SW: begin
                is_mem      = 1'b1;
                is_store    = 1'b1;
                misaligned  = |addr_lo;
                be          = 4'b1111;
                store_lanes = store_data;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage load/store sequencer onto a req/ack data bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              we_i,
    output logic [REG_AW-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              stallreq_o,
    output logic              exc_align_o,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [3:0]        dbus_be_o,
    output logic [DATA_W-1:0] dbus_addr_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_ack_i,
    input  logic [DATA_W-1:0] dbus_rdata_i
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_load_data;

    logic              w_is_mem;
    logic              w_is_store;
    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_store_lanes;
    logic [DATA_W-1:0] w_load_ext;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .op          (mem_op_i),
        .addr_lo     (mem_addr_i[1:0]),
        .store_data  (mem_wdata_i),
        .rdata       (dbus_rdata_i),
        .is_mem      (w_is_mem),
        .is_store    (w_is_store),
        .misaligned  (w_misaligned),
        .be          (w_be),
        .store_lanes (w_store_lanes),
        .load_ext    (w_load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_load_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_BUSY && dbus_ack_i) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    // The stall keeps the EX/MEM inputs stable, so bus fields are derived live
    always_comb begin
        w_state_nxt  = r_state;
        waddr_o      = '0;
        wdata_o      = '0;
        we_o         = 1'b0;
        stallreq_o   = 1'b0;
        exc_align_o  = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_be_o    = 4'b0000;
        dbus_addr_o  = '0;
        dbus_wdata_o = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_is_mem) begin
                        waddr_o = waddr_i;
                        wdata_o = wdata_i;
                        we_o    = we_i;
                    end else if (w_misaligned) begin
                        exc_align_o = 1'b1;
                    end else begin
                        stallreq_o  = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    stallreq_o   = 1'b1;
                    dbus_req_o   = 1'b1;
                    dbus_we_o    = w_is_store;
                    dbus_be_o    = w_be;
                    dbus_addr_o  = {mem_addr_i[DATA_W-1:2], 2'b00};
                    dbus_wdata_o = w_store_lanes;
                    if (dbus_ack_i) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!w_is_store) begin
                        waddr_o = waddr_i;
                        wdata_o = r_load_data;
                        we_o    = we_i;
                    end
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam logic [3:0] c_NONE = 4'd0;
    localparam logic [3:0] c_LB   = 4'd1;
    localparam logic [3:0] c_LBU  = 4'd2;
    localparam logic [3:0] c_LH   = 4'd3;
    localparam logic [3:0] c_LHU  = 4'd4;
    localparam logic [3:0] c_LW   = 4'd5;
    localparam logic [3:0] c_SB   = 4'd6;
    localparam logic [3:0] c_SH   = 4'd7;
    localparam logic [3:0] c_SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        we_o;
    logic        stallreq_o;
    logic        exc_align_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_op_i     (mem_op_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .we_i         (we_i),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .we_o         (we_o),
        .stallreq_o   (stallreq_o),
        .exc_align_o  (exc_align_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_ack_i   (dbus_ack_i),
        .dbus_rdata_i (dbus_rdata_i)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One aligned access: IDLE cycle, (waits+1) BUSY cycles, DONE cycle
    task automatic do_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                             input logic [3:0] exp_be, input logic exp_dwe, input logic [31:0] exp_daddr,
                             input logic [31:0] exp_dwdata, input logic exp_we, input logic [31:0] exp_res);
        int stalls;
        stalls = 0;
        next_cycle();
        mem_op_i = op; mem_addr_i = addr; mem_wdata_i = sdata;
        waddr_i = 5'd7; wdata_i = 32'h5555_AAAA; we_i = 1'b1;
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        @(negedge clk);
        if (stallreq_o) stalls++;
        check_value({tag, " idle_req"}, {31'd0, dbus_req_o}, 32'd0);
        check_value({tag, " idle_we"}, {31'd0, we_o}, 32'd0);
        for (int i = 0; i <= waits; i++) begin
            next_cycle();
            if (i == waits) begin
                dbus_ack_i = 1'b1; dbus_rdata_i = rdata;
            end
            @(negedge clk);
            if (stallreq_o) stalls++;
            check_value({tag, " busy_req"}, {31'd0, dbus_req_o}, 32'd1);
            check_value({tag, " busy_we"}, {31'd0, we_o}, 32'd0);
            check_value({tag, " be"}, {28'd0, dbus_be_o}, {28'd0, exp_be});
            check_value({tag, " dbus_we"}, {31'd0, dbus_we_o}, {31'd0, exp_dwe});
            check_value({tag, " dbus_addr"}, dbus_addr_o, exp_daddr);
            if (exp_dwe) check_value({tag, " dbus_wdata"}, dbus_wdata_o, exp_dwdata);
        end
        next_cycle();
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'h1234_5678;
        @(negedge clk);
        if (stallreq_o) stalls++;
        check_value({tag, " done_req"}, {31'd0, dbus_req_o}, 32'd0);
        check_value({tag, " done_we"}, {31'd0, we_o}, {31'd0, exp_we});
        if (exp_we) begin
            check_value({tag, " done_wdata"}, wdata_o, exp_res);
            check_value({tag, " done_waddr"}, {27'd0, waddr_o}, 32'd7);
        end
        check_value({tag, " stall_cycles"}, stalls, waits + 2);
        next_cycle();
        mem_op_i = c_NONE;
        @(negedge clk);
        check_value({tag, " back_idle_stall"}, {31'd0, stallreq_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_op_i = c_NONE; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        waddr_i = 5'd3; wdata_i = 32'h1234; we_i = 1'b1;
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;

        // Outputs must be forced low while reset is held
        @(negedge clk);
        check_value("rst we_o", {31'd0, we_o}, 32'd0);
        check_value("rst wdata_o", wdata_o, 32'd0);
        check_value("rst waddr_o", {27'd0, waddr_o}, 32'd0);
        check_value("rst stall", {31'd0, stallreq_o}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // ALU pass-through
        @(negedge clk);
        check_value("alu waddr", {27'd0, waddr_o}, 32'd3);
        check_value("alu wdata", wdata_o, 32'h1234);
        check_value("alu we", {31'd0, we_o}, 32'd1);
        check_value("alu stall", {31'd0, stallreq_o}, 32'd0);
        check_value("alu req", {31'd0, dbus_req_o}, 32'd0);

        do_access("lb",  c_LB,  32'h103, 32'h0, 32'h80FF_0000, 0, 4'b1000, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFF_FF80);
        do_access("lhu", c_LHU, 32'h102, 32'h0, 32'hBEEF_0000, 3, 4'b1100, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000_BEEF);
        do_access("lh",  c_LH,  32'h100, 32'h0, 32'h0000_8001, 1, 4'b0011, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFF_8001);
        do_access("lbu", c_LBU, 32'h101, 32'h0, 32'h0000_F000, 0, 4'b0010, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000_00F0);
        do_access("lw",  c_LW,  32'h108, 32'h0, 32'hCAFE_BABE, 0, 4'b1111, 1'b0, 32'h108, 32'h0, 1'b1, 32'hCAFE_BABE);
        do_access("sb",  c_SB,  32'h201, 32'h0000_00AB, 32'h0, 0, 4'b0010, 1'b1, 32'h200, 32'hABAB_ABAB, 1'b0, 32'h0);
        do_access("sh",  c_SH,  32'h202, 32'h1234_CAFE, 32'h0, 2, 4'b1100, 1'b1, 32'h200, 32'hCAFE_CAFE, 1'b0, 32'h0);
        do_access("sw",  c_SW,  32'h204, 32'h1122_3344, 32'h0, 0, 4'b1111, 1'b1, 32'h204, 32'h1122_3344, 1'b0, 32'h0);

        // Misaligned accesses raise a one-cycle exception and no bus traffic
        next_cycle();
        mem_op_i = c_LW; mem_addr_i = 32'h102; we_i = 1'b1;
        @(negedge clk);
        check_value("misal lw exc", {31'd0, exc_align_o}, 32'd1);
        check_value("misal lw req", {31'd0, dbus_req_o}, 32'd0);
        check_value("misal lw we", {31'd0, we_o}, 32'd0);
        check_value("misal lw stall", {31'd0, stallreq_o}, 32'd0);
        next_cycle();
        mem_op_i = c_SH; mem_addr_i = 32'h203;
        @(negedge clk);
        check_value("misal sh exc", {31'd0, exc_align_o}, 32'd1);
        check_value("misal sh req", {31'd0, dbus_req_o}, 32'd0);
        next_cycle();
        mem_op_i = c_NONE;
        @(negedge clk);
        check_value("misal clear exc", {31'd0, exc_align_o}, 32'd0);
        check_value("misal clear stall", {31'd0, stallreq_o}, 32'd0);

        // Reset while BUSY, then a late ack that must be ignored
        next_cycle();
        mem_op_i = c_LW; mem_addr_i = 32'h300; we_i = 1'b0;
        next_cycle();
        @(negedge clk);
        check_value("rstbusy req", {31'd0, dbus_req_o}, 32'd1);
        next_cycle();
        rst = 1'b1; mem_op_i = c_NONE;
        @(negedge clk);
        check_value("rstbusy held req", {31'd0, dbus_req_o}, 32'd0);
        check_value("rstbusy held stall", {31'd0, stallreq_o}, 32'd0);
        next_cycle();
        rst = 1'b0; dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check_value("late ack req", {31'd0, dbus_req_o}, 32'd0);
        check_value("late ack stall", {31'd0, stallreq_o}, 32'd0);
        check_value("late ack we", {31'd0, we_o}, 32'd0);
        next_cycle();
        dbus_ack_i = 1'b0;
        @(negedge clk);
        check_value("post ack req", {31'd0, dbus_req_o}, 32'd0);
        check_value("post ack stall", {31'd0, stallreq_o}, 32'd0);

        do_access("recover", c_LB, 32'h100, 32'h0, 32'h0000_007F, 0, 4'b0001, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000_007F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
